// File: rtl/freq_pkg.sv
// Shared types and constants for the frequency meter and its edge detector.
package freq_pkg;

    // Default width of the period counter and the result registers
    localparam int CNT_W_DEF = 31;

    // Number of flops that re-time an asynchronous input into the clk domain
    localparam int SYNC_STAGES = 2;

    // Measurement states: waiting for a first edge, counting, and lost signal
    typedef enum logic [1:0] {
        IDLE,
        MEAS,
        TO
    } state_t;

endpackage

// File: rtl/sync_edge.sv
// Synchronizes an asynchronous input and produces one-cycle rise/fall pulses.
module sync_edge
    import freq_pkg::*;
(
    input  logic clk,
    input  logic rstn,
    input  logic async_i,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   delay_q;

    // Re-time the input through the synchronizer chain, then delay it one more cycle for edge detection
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q  <= '0;
            delay_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], async_i};
            delay_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise_o = sync_q[SYNC_STAGES-1] & ~delay_q;
    assign fall_o = ~sync_q[SYNC_STAGES-1] & delay_q;

endmodule

// File: rtl/freq_meter.sv
// Measures period and high time of an asynchronous square wave in clk cycles.
module freq_meter
    import freq_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int TIMEOUT = 1000000
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             locked,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

    logic rise;
    logic fall;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] hiLat_q;
    logic [CNT_W-1:0] period_q;
    logic [CNT_W-1:0] highTime_q;
    logic             valid_q;
    logic             locked_q;
    logic             timeout_q;

    sync_edge u_sync_edge (
        .clk     (clk),
        .rstn    (rstn),
        .async_i (sig_in),
        .rise_o  (rise),
        .fall_o  (fall)
    );

    assign cnt_d = cnt_q + ONE_C;

    // Measurement FSM: counts cycles between rises, latches the high time on fall, reports on rise
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            hiLat_q    <= '0;
            period_q   <= '0;
            highTime_q <= '0;
            valid_q    <= 1'b0;
            locked_q   <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (clr) begin
                state_q   <= IDLE;
                locked_q  <= 1'b0;
                timeout_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (rise) begin
                            state_q <= MEAS;
                            cnt_q   <= ONE_C;
                        end
                    end
                    MEAS: begin
                        if (rise) begin
                            period_q   <= cnt_q;
                            highTime_q <= hiLat_q;
                            valid_q    <= 1'b1;
                            locked_q   <= 1'b1;
                            cnt_q      <= ONE_C;
                        end else begin
                            cnt_q <= cnt_d;
                            if (fall) begin
                                hiLat_q <= cnt_q;
                            end
                            if (cnt_q == TIMEOUT_C) begin
                                state_q   <= TO;
                                timeout_q <= 1'b1;
                                locked_q  <= 1'b0;
                            end
                        end
                    end
                    TO: begin
                        if (rise) begin
                            state_q   <= MEAS;
                            timeout_q <= 1'b0;
                            cnt_q     <= ONE_C;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign period    = period_q;
    assign high_time = highTime_q;
    assign valid     = valid_q;
    assign locked    = locked_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_freq_meter.sv
// Scoreboard bench for freq_meter: waveform-level reference model, decoupled monitor.
module tb_freq_meter;

    localparam int CNT_W   = 31;
    localparam int TIMEOUT = 100;

    logic             clk;
    logic             rstn;
    logic             clr;
    logic             sig_in;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             valid;
    logic             locked;
    logic             timeout;

    typedef struct {
        int p;
        int h;
        int c;
    } exp_t;

    exp_t sbq[$];

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;

    // Reference model state, expressed in bench drive-cycle indices
    bit armed      = 1'b0;
    int lastRise   = 0;
    int lastFall   = 0;
    bit holdLocked = 1'b0;

    freq_meter #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .clr       (clr),
        .sig_in    (sig_in),
        .period    (period),
        .high_time (high_time),
        .valid     (valid),
        .locked    (locked),
        .timeout   (timeout)
    );

    // Free-running clock, 10 time units per cycle
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle index used to time stimulus and expected results
    always @(posedge clk) cyc <= cyc + 1;

    // Hard stop in case something keeps the run going
    always @(posedge clk) begin
        if (cyc > 20000) begin
            $display("[TB] FAIL watchdog: got cycle %0d, expected below 20000", cyc);
            $fatal(1, "[TB] watchdog expired");
        end
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic stepCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // A rise of the measured wave at drive cycle k completes the interval opened by the previous rise
    task automatic noteRise(input int k);
        exp_t e;
        if (armed && (k - lastRise) <= TIMEOUT) begin
            e.p = k - lastRise;
            e.h = lastFall - lastRise;
            e.c = k + 3;
            sbq.push_back(e);
        end
        armed    = 1'b1;
        lastRise = k;
    endtask

    task automatic applyStimulus(input int h, input int l);
        sig_in = 1'b1;
        noteRise(cyc);
        stepCycles(h);
        sig_in   = 1'b0;
        lastFall = cyc;
        stepCycles(l);
    endtask

    // Monitor: pops the scoreboard whenever the DUT reports, and flags missing or extra results
    always @(negedge clk) begin
        if (sbq.size() > 0 && cyc > sbq[0].c) begin
            checkOutput("missing valid", 0, 1);
            void'(sbq.pop_front());
        end
        if (valid) begin
            if (sbq.size() == 0) begin
                checkOutput("unexpected valid", 1, 0);
            end else begin
                checkOutput("valid cycle", cyc, sbq[0].c);
                checkOutput("period", int'(period), sbq[0].p);
                checkOutput("high_time", int'(high_time), sbq[0].h);
                checkOutput("locked at valid", int'(locked), 1);
                checkOutput("timeout at valid", int'(timeout), 0);
                void'(sbq.pop_front());
            end
        end
        if (holdLocked) begin
            checkOutput("locked held", int'(locked), 1);
        end
    end

    initial begin
        int target;
        int k;

        rstn   = 1'b0;
        clr    = 1'b0;
        sig_in = 1'b0;
        #2;
        checkOutput("reset period", int'(period), 0);
        checkOutput("reset high_time", int'(high_time), 0);
        checkOutput("reset valid", int'(valid), 0);
        checkOutput("reset locked", int'(locked), 0);
        checkOutput("reset timeout", int'(timeout), 0);
        stepCycles(3);
        rstn = 1'b1;
        stepCycles(2);

        $display("[TB] divide-by-4 lock");
        repeat (6) applyStimulus(2, 2);

        $display("[TB] 3/4 waveform, 1/1 switch, random periods");
        repeat (2) applyStimulus(3, 4);
        holdLocked = 1'b1;
        applyStimulus(3, 4);
        repeat (4) applyStimulus(1, 1);
        repeat (20) applyStimulus(int'($urandom_range(10, 1)), int'($urandom_range(10, 1)));
        holdLocked = 1'b0;

        $display("[TB] timeout after signal stops");
        target = lastRise + 2 + TIMEOUT;
        while (cyc < target) @(negedge clk);
        checkOutput("timeout before limit", int'(timeout), 0);
        checkOutput("locked before limit", int'(locked), 1);
        @(negedge clk);
        checkOutput("timeout at limit", int'(timeout), 1);
        checkOutput("locked at limit", int'(locked), 0);
        @(posedge clk);
        #1;
        repeat (4) applyStimulus(2, 2);
        checkOutput("timeout after restart", int'(timeout), 0);

        $display("[TB] period equal to TIMEOUT");
        repeat (3) applyStimulus(50, 50);
        repeat (3) applyStimulus(2, 2);
        checkOutput("timeout after max period", int'(timeout), 0);

        $display("[TB] clear on a rise cycle");
        sig_in = 1'b1;
        k      = cyc;
        armed  = 1'b0;
        stepCycles(2);
        sig_in = 1'b0;
        clr    = 1'b1;
        stepCycles(1);
        clr = 1'b0;
        @(negedge clk);
        checkOutput("clr cycle index", cyc, k + 3);
        checkOutput("clr valid", int'(valid), 0);
        checkOutput("clr locked", int'(locked), 0);
        checkOutput("clr timeout", int'(timeout), 0);
        checkOutput("clr period held", int'(period), 4);
        checkOutput("clr high_time held", int'(high_time), 2);
        @(posedge clk);
        #1;
        repeat (4) applyStimulus(2, 2);

        $display("[TB] asynchronous reset mid-period");
        stepCycles(1);
        #3;
        rstn = 1'b0;
        #1;
        checkOutput("async reset period", int'(period), 0);
        checkOutput("async reset high_time", int'(high_time), 0);
        checkOutput("async reset locked", int'(locked), 0);
        checkOutput("async reset valid", int'(valid), 0);
        armed = 1'b0;
        stepCycles(2);
        rstn = 1'b1;
        stepCycles(1);
        repeat (4) applyStimulus(2, 2);

        stepCycles(10);
        checkOutput("scoreboard drained", sbq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/freq_meter.md
# freq_meter

Measures the period and high time of an asynchronous square wave `sig_in` in units of `clk` cycles, and reports one result per input period. This is the measurement end of the team's clock-divider blocks: a divider's output drives `sig_in`, and the meter reports the achieved ratio and duty cycle. It serves as the on-chip check on the divided clocks and as a general tachometer input.

## Interface
Parameters:
- `CNT_W`, default 31: width of the period counter and the result registers.
- `TIMEOUT`, default 1000000: longest accepted period, in `clk` cycles. Legal range is 2 to 2^CNT_W−1.

Ports:
- `clk`, input, 1 bit: system clock. All logic is rising-edge.
- `rstn`, input, 1 bit: reset, asynchronous, active-low.
- `clr`, input, 1 bit: synchronous clear. Returns the block to IDLE.
- `sig_in`, input, 1 bit: measured signal. Asynchronous to `clk`.
- `period`, output, `CNT_W` bits: last measured period, in cycles.
- `high_time`, output, `CNT_W` bits: last measured high time, in cycles.
- `valid`, output, 1 bit: one-cycle pulse that marks a new `period`/`high_time` pair.
- `locked`, output, 1 bit: level. At least one result has been reported and no timeout has occurred since.
- `timeout`, output, 1 bit: level. No rising edge has arrived within `TIMEOUT` cycles.

## Operation
- `sig_in` passes through 2 synchronizer flops, then a third delay flop.
- `rise` = stage2 & ~stage3; `fall` = ~stage2 & stage3. Each lasts 1 cycle.
- Counter `cnt` (`CNT_W` bits):
  - On a `rise` cycle, `cnt` loads 1.
  - In every other cycle in state MEAS, `cnt` increments by 1.
  - In IDLE and TO, `cnt` holds.
- State IDLE (entered on reset and on `clr`):
  - `fall` is ignored.
  - `rise` moves to MEAS and loads `cnt` to 1.
  - No result is reported and no timeout is raised.
- State MEAS:
  - `fall` latches `hi_lat` <= `cnt`.
  - `rise` loads `period` <= `cnt` and `high_time` <= `hi_lat`, pulses `valid`, and sets `locked`.
  - If `cnt` == `TIMEOUT` with no `rise`, the state moves to TO: `timeout` is set and `locked` is cleared.
- State TO:
  - `rise` moves to MEAS, clears `timeout`, and loads `cnt` to 1.
  - No `valid` is produced on that edge, because the interval is meaningless.
- The first `rise` after IDLE or TO only starts a measurement. The first `valid` comes on the second `rise`.
- Results: the rise-to-rise cycle count is P and the rise-to-fall count is H.
  - `sig_in` waveforms synchronous to `clk` are measured exactly.
  - Asynchronous waveforms are measured to ±1 cycle, from synchronizer sampling.
- Minimum measurable waveform is period 2 (1 high, 1 low). Faster inputs alias: results are undefined, but the FSM must not hang.
- `period` and `high_time` hold their value until the next `valid`. `clr` does not clear them.

## Timing
- Reset values: `period`=0, `high_time`=0, `valid`=0, `locked`=0, `timeout`=0, state IDLE, `cnt`=0.
- An edge on `sig_in` that meets setup before clock edge n produces `rise` (or `fall`) in the cycle after edge n+1.
- `valid`, `period` and `high_time` update at the clock edge that ends the `rise` cycle. Total latency from the `sig_in` edge is 3 clock edges.
- `timeout` rises at the edge that ends the cycle in which `cnt` == `TIMEOUT`.
- Simultaneous events:
  - `rise` and `cnt` == `TIMEOUT` in the same cycle: `rise` wins. A result is reported with `period` = `TIMEOUT`, so the maximum reportable period is `TIMEOUT`.
  - `clr` and `rise` in the same cycle: `clr` wins. The state goes to IDLE, no `valid` is produced, and `locked` and `timeout` are cleared.
- `rstn` asserted mid-measurement: all state and outputs return to reset values immediately. The synchronizer flops also reset to 0.

## Structure
- Package `freq_pkg` holds:
  - state enum `{IDLE, MEAS, TO}`;
  - `CNT_W` default constant;
  - `SYNC_STAGES` = 2.
- Sub-module `sync_edge`, which takes an asynchronous input and produces `rise`/`fall` pulses:
  - 2-flop synchronizer plus delay flop;
  - reset to 0;
  - generic, reused for other asynchronous inputs.
- Top level contains the FSM, `cnt`, `hi_lat` and the output registers.

## Test plan
- Divide-by-4 stimulus (clk-synchronous, 2 high / 2 low) → after the second rise, `valid` every 4 cycles with `period`=4, `high_time`=2, and `locked`=1.
- Bench-driven waveform with 3 high / 4 low → `period`=7, `high_time`=3. A switch to 1 high / 1 low → next `valid` reports 2 and 1, with no gap in `locked`.
- `TIMEOUT`=100, `sig_in` held low after a lock → `timeout`=1 and `locked`=0 exactly 100 cycles after the last `rise`. Restarting the 4-cycle input → no `valid` on the first rise, then `valid` with 4 and 2.
- Rise arriving exactly at `cnt`=`TIMEOUT` (period 100, `TIMEOUT`=100) → `valid` with `period`=100, and `timeout` stays 0.
- `clr` pulsed on a rise cycle while locked → IDLE, `locked`=0, no `valid`, old `period` still held. The first new `valid` comes 2 periods later.
- `rstn` asserted mid-period while locked → all outputs 0 asynchronously. After release, the block needs 2 rises before `valid`.
